// File: rtl/dac_raw_sample_capture.sv
// Triggered DAC tap capture: packs two samples per AXI-Stream beat for DMA to PS memory.
// Define RAW_SAVE_HEADER_EN to prefix each capture with a header beat {pad, 8'hA5, N[23:0]}.
module dac_raw_sample_capture #(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 24,
  parameter int OUT_WIDTH   = 2*DATA_WIDTH
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic [OUT_WIDTH-1:0]   m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  input  logic                   i_trigger,
  input  logic [COUNT_WIDTH-1:0] i_dac_sample_save,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_overflow,
  output logic [1:0]             o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_trig_prev;
  logic [COUNT_WIDTH-1:0] r_n;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0]  r_pack_lo;
  logic [OUT_WIDTH-1:0]   r_tdata;
  logic                   r_tvalid;
  logic                   r_tlast;
  logic                   r_overflow;

  logic                   w_rise;
  logic                   w_fire;
  logic [COUNT_WIDTH-1:0] w_cnt_inc;
  logic                   w_last;
  logic                   w_commit;
  logic [OUT_WIDTH-1:0]   w_word;
  logic                   w_accept;
  logic                   w_can_load;

  assign w_rise     = i_trigger & ~r_trig_prev;
  assign w_fire     = (r_state == ST_CAPTURE) & s_axis_tvalid;
  assign w_cnt_inc  = r_cnt + CNT_ONE;
  assign w_last     = (w_cnt_inc == r_n);
  // Odd-indexed samples close a pair; an even-indexed final sample closes a half-empty word.
  assign w_commit   = w_fire & (r_cnt[0] | w_last);
  assign w_word     = r_cnt[0] ? OUT_WIDTH'({s_axis_tdata, r_pack_lo}) : OUT_WIDTH'(s_axis_tdata);

  // Output handshake: a beat transfers on a rising edge where m_axis_tvalid and
  // m_axis_tready are both high; while tvalid is high and tready low, tdata and
  // tvalid hold (tlast may only rise, when a dropped final word passes its flag on).
  assign w_accept   = r_tvalid & m_axis_tready;
  assign w_can_load = ~r_tvalid | m_axis_tready;

`ifdef RAW_SAVE_HEADER_EN
  logic [OUT_WIDTH-1:0] w_hdr;
  assign w_hdr = OUT_WIDTH'({8'hA5, 24'(i_dac_sample_save)});
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_next_state = (i_dac_sample_save != '0) ? ST_CAPTURE : ST_DONE;
        end
      end
      ST_CAPTURE: begin
        o_busy = 1'b1;
        if (w_commit && w_last) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        o_busy = 1'b1;
        if (w_accept) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        o_done = 1'b1;
        if (!i_trigger) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_trig_prev <= 1'b0;
      r_n         <= '0;
      r_cnt       <= '0;
      r_pack_lo   <= '0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_trig_prev <= i_trigger;
      if (w_accept) begin
        r_tvalid <= 1'b0;
      end
      if ((r_state == ST_IDLE) && w_rise) begin
        r_n        <= i_dac_sample_save;
        r_cnt      <= '0;
        r_pack_lo  <= '0;
        r_overflow <= 1'b0;
`ifdef RAW_SAVE_HEADER_EN
        if (i_dac_sample_save != '0) begin
          r_tdata  <= w_hdr;
          r_tvalid <= 1'b1;
          r_tlast  <= 1'b0;
        end
`endif
      end
      if (w_fire) begin
        r_cnt <= w_cnt_inc;
        if (!r_cnt[0]) begin
          r_pack_lo <= s_axis_tdata;
        end
        if (w_commit) begin
          if (w_can_load) begin
            r_tdata  <= w_word;
            r_tvalid <= 1'b1;
            r_tlast  <= w_last;
          end else begin
            // Word lost; the held beat inherits tlast so the capture still terminates.
            r_overflow <= 1'b1;
            if (w_last) begin
              r_tlast <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign o_overflow    = r_overflow;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_dac_raw_sample_capture.sv
// Self-checking bench for dac_raw_sample_capture: directed vector table, hand sequences
// (N=0, mid-capture reset) and randomized captures against an ideal-beat reference.
module tb_dac_raw_sample_capture;
  localparam int DW = 16;
  localparam int CW = 24;
  localparam int OW = 32;
`ifdef RAW_SAVE_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic [OW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic          trig = 1'b0;
  logic [CW-1:0] save_n = '0;
  logic          busy;
  logic          done;
  logic          ovf;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [OW:0]   got_q[$];   // {tlast, tdata} of accepted beats
  logic [OW-1:0] exp_q[$];   // ideal beat sequence with no drops
  logic [DW-1:0] samp_q[$];  // samples offered after the trigger

  always #5 aclk = ~aclk;

  dac_raw_sample_capture #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .OUT_WIDTH(OW)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .i_trigger(trig), .i_dac_sample_save(save_n),
    .o_busy(busy), .o_done(done), .o_overflow(ovf), .o_dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Monitor: records handshakes and checks that a stalled beat holds.
  logic          mon_stalled = 1'b0;
  logic [OW-1:0] mon_data = '0;
  always @(negedge aclk) begin
    if (areset) begin
      mon_stalled = 1'b0;
    end else begin
      if (mon_stalled) begin
        check("hold_tvalid", m_tvalid, 1);
        check("hold_tdata", m_tdata, mon_data);
      end
      if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
      mon_stalled = m_tvalid && !m_tready;
      mon_data    = m_tdata;
    end
  end

  task automatic build_ideal(input int n);
    logic [DW-1:0] lo, hi;
    exp_q.delete();
    if (HDR && n > 0) exp_q.push_back(OW'({8'hA5, 24'(n)}));
    for (int i = 0; i < n; i += 2) begin
      lo = samp_q[i];
      hi = (i + 1 < n) ? samp_q[i+1] : '0;
      exp_q.push_back({hi, lo});
    end
  endtask

  // Caller has driven trig=1 / save_n=n for the coming edge (or releases reset with trig high).
  task automatic capture_body(input int n, input int stall, input int gap_pct, input int nrdy_pct,
                              input bit glitch, input int exp_beats, input int exp_ovf);
    int sent, slot, waited, j, nl;
    bit ok;
    logic [OW:0] g;
    got_q.delete();
    build_ideal(n);
    m_tready = (stall > 0) ? 1'b0 : 1'b1;
    step();
    check("busy_after_trigger", busy, 1);
    sent = 0;
    slot = 1;
    while (sent < samp_q.size()) begin
      m_tready = (slot < stall) ? 1'b0 : (($urandom_range(99) < nrdy_pct) ? 1'b0 : 1'b1);
      trig = !(glitch && slot == 3);
      if ($urandom_range(99) < gap_pct) begin
        s_tvalid = 1'b0;
      end else begin
        s_tvalid = 1'b1;
        s_tdata  = samp_q[sent];
        sent++;
      end
      step();
      slot++;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    trig = 1'b1;
    waited = 0;
    while (!done && waited < 300) begin
      step();
      waited++;
    end
    check("done_reached", done, 1);
    check("busy_at_done", busy, 0);
    check("tvalid_at_done", m_tvalid, 0);
    if (exp_beats >= 0) check("beat_count", got_q.size(), exp_beats);
    if (exp_ovf >= 0) check("overflow", ovf, exp_ovf);
    else check("overflow_vs_drops", ovf, got_q.size() < exp_q.size());
    ok = 1'b1;
    j = 0;
    nl = 0;
    foreach (got_q[i]) begin
      g = got_q[i];
      if (g[OW]) nl++;
      while (j < exp_q.size() && exp_q[j] != g[OW-1:0]) j++;
      if (j >= exp_q.size()) ok = 1'b0;
      else j++;
    end
    check("beats_in_order", ok, 1);
    if (got_q.size() == exp_q.size()) begin
      foreach (got_q[i]) begin
        g = got_q[i];
        check("beat_data", g[OW-1:0], exp_q[i]);
      end
    end
    check("tlast_count", nl, 1);
    if (got_q.size() > 0) begin
      g = got_q[got_q.size()-1];
      check("tlast_on_final", g[OW], 1);
    end
    trig = 1'b0;
    step();
    check("done_clears", done, 0);
    check("state_idle", dbg_state, 0);
  endtask

  typedef struct {
    int n;
    int nsamp;
    int base;
    int stall;
    bit glitch;
    int beats;
    int beats_hdr;
    int ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    vecs[0] = '{8, 20, 0, 0, 1'b0, 4, 5, 0};
    vecs[1] = '{5, 10, 0, 0, 1'b0, 3, 4, 0};
    vecs[2] = '{5, 10, 100, 0, 1'b0, 3, 4, 0};
    vecs[3] = '{8, 12, 0, 6, 1'b0, 3, 3, 1};
    vecs[4] = '{1, 3, 200, 0, 1'b0, 1, 2, 0};
    vecs[5] = '{2, 4, 300, 0, 1'b0, 1, 2, 0};
    vecs[6] = '{10, 12, 400, 0, 1'b1, 5, 6, 0};

    repeat (3) step();
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", ovf, 0);
    check("rst_state", dbg_state, 0);
    areset = 1'b0;
    step();

    foreach (vecs[v]) begin
      samp_q.delete();
      for (int k = 1; k <= vecs[v].nsamp; k++) samp_q.push_back(DW'(vecs[v].base + k));
      trig = 1'b1;
      save_n = CW'(vecs[v].n);
      s_tvalid = 1'b0;
      capture_body(vecs[v].n, vecs[v].stall, 0, 0, vecs[v].glitch,
                   HDR ? vecs[v].beats_hdr : vecs[v].beats, vecs[v].ovf);
      step();
    end

    // N = 0: straight to DONE, never busy, no beats.
    got_q.delete();
    trig = 1'b1;
    save_n = '0;
    step();
    check("n0_done_next_cycle", done, 1);
    check("n0_busy", busy, 0);
    repeat (3) begin
      step();
      check("n0_busy_hold", busy, 0);
      check("n0_no_tvalid", m_tvalid, 0);
    end
    check("n0_beats", got_q.size(), 0);
    trig = 1'b0;
    step();
    check("n0_done_clears", done, 0);

    // Reset after three samples, then trigger held high through release restarts at index 0.
    trig = 1'b1;
    save_n = CW'(8);
    m_tready = 1'b1;
    step();
    for (int k = 1; k <= 3; k++) begin
      s_tvalid = 1'b1;
      s_tdata = DW'(k);
      step();
    end
    s_tvalid = 1'b0;
    areset = 1'b1;
    step();
    check("mid_rst_tvalid", m_tvalid, 0);
    check("mid_rst_tdata", m_tdata, 0);
    check("mid_rst_tlast", m_tlast, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_overflow", ovf, 0);
    check("mid_rst_state", dbg_state, 0);
    areset = 1'b0;
    save_n = CW'(2);
    samp_q.delete();
    samp_q.push_back(16'h0100);
    samp_q.push_back(16'h0101);
    capture_body(2, 0, 0, 0, 1'b0, HDR ? 2 : 1, 0);
    step();

    // Randomized captures with gaps and downstream back-pressure.
    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(14, 1);
      samp_q.delete();
      for (int k = 0; k < n + int'($urandom_range(3, 0)); k++) samp_q.push_back(DW'($urandom));
      trig = 1'b1;
      save_n = CW'(n);
      s_tvalid = 1'b0;
      capture_body(n, 0, 20, $urandom_range(60, 0), 1'b0, -1, -1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
